// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator with a pixel-clock prescaler.
// It produces sync, display-enable, coordinates, line/frame strobes and a frame counter.
`timescale 1ns/1ps
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int PIX_DIV  = 1,
  parameter int CNT_W    = 10,
  parameter int FRAME_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  output logic               pix_en,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic [CNT_W-1:0]   x,
  output logic [CNT_W-1:0]   y,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_BEG  = H_ACTIVE + H_FP;
  localparam int HS_END  = H_ACTIVE + H_FP + H_SYNC;
  localparam int VS_BEG  = V_ACTIVE + V_FP;
  localparam int VS_END  = V_ACTIVE + V_FP + V_SYNC;
  localparam int P_W     = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [P_W-1:0]   P_LAST = P_W'(PIX_DIV - 1);

  if (((longint'(1) << CNT_W) < longint'(H_TOTAL)) ||
      ((longint'(1) << CNT_W) < longint'(V_TOTAL)) || (PIX_DIV < 1)) begin : g_bad_cfg
    $error("vga_timing_gen: CNT_W too narrow for the mode, or PIX_DIV < 1");
  end

  logic [P_W-1:0]     p_q, p_d;
  logic               pix_en_q, pix_en_d;
  logic [CNT_W-1:0]   h_q, h_d, v_q, v_d;
  logic               hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
  logic [CNT_W-1:0]   x_q, x_d, y_q, y_d;
  logic               line_start_q, line_start_d, frame_start_q, frame_start_d;
  logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    p_d           = p_q + P_W'(1);
    pix_en_d      = 1'b0;
    h_d           = h_q;
    v_d           = v_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    de_d          = de_q;
    x_d           = x_q;
    y_d           = y_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    frame_cnt_d   = frame_cnt_q;

    if (p_q == P_LAST) begin
      p_d      = '0;
      pix_en_d = 1'b1;
    end

    // Outputs are decoded from the next position so they line up with the counters.
    if (pix_en_q) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + CNT_W'(1);
      end else begin
        h_d = h_q + CNT_W'(1);
      end
      de_d    = (int'(h_d) < H_ACTIVE) && (int'(v_d) < V_ACTIVE);
      x_d     = de_d ? h_d : '0;
      y_d     = de_d ? v_d : '0;
      hsync_d = ((int'(h_d) >= HS_BEG) && (int'(h_d) < HS_END)) ? H_POL : ~H_POL;
      vsync_d = ((int'(v_d) >= VS_BEG) && (int'(v_d) < VS_END)) ? V_POL : ~V_POL;
      line_start_d  = (h_d == '0);
      frame_start_d = (h_d == '0) && (v_d == '0);
      if (frame_start_d) frame_cnt_d = frame_cnt_q + FRAME_W'(1);
    end
  end

  // Reset parks the position on the last blanking pixel so the first advance lands on (0,0).
  always_ff @(posedge clk) begin
    if (rst) begin
      p_q           <= '0;
      pix_en_q      <= 1'b0;
      h_q           <= H_LAST;
      v_q           <= V_LAST;
      hsync_q       <= ~H_POL;
      vsync_q       <= ~V_POL;
      de_q          <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      p_q           <= p_d;
      pix_en_q      <= pix_en_d;
      h_q           <= h_d;
      v_q           <= v_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign pix_en      = pix_en_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign x           = x_q;
  assign y           = y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default mode at PIX_DIV 4 and 1, plus a small mode
// in both sync polarities with a 2-bit frame counter.
`timescale 1ns/1ps
module tb_vga_timing_gen;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Default mode, PIX_DIV=4
  logic d4_pix_en, d4_hsync, d4_vsync, d4_de, d4_ls, d4_fs;
  logic [9:0] d4_x, d4_y;
  logic [7:0] d4_fc;
  // Default mode, PIX_DIV=1
  logic d1_pix_en, d1_hsync, d1_vsync, d1_de, d1_ls, d1_fs;
  logic [9:0] d1_x, d1_y;
  logic [7:0] d1_fc;
  // Small mode, active-low syncs
  logic sm_pix_en, sm_hsync, sm_vsync, sm_de, sm_ls, sm_fs;
  logic [9:0] sm_x, sm_y;
  logic [1:0] sm_fc;
  // Small mode, active-high syncs
  logic sp_pix_en, sp_hsync, sp_vsync, sp_de, sp_ls, sp_fs;
  logic [9:0] sp_x, sp_y;
  logic [1:0] sp_fc;

  vga_timing_gen #(.PIX_DIV(4)) u_d4 (
    .clk(clk), .rst(rst), .pix_en(d4_pix_en), .hsync(d4_hsync), .vsync(d4_vsync),
    .de(d4_de), .x(d4_x), .y(d4_y), .line_start(d4_ls), .frame_start(d4_fs),
    .frame_cnt(d4_fc));

  vga_timing_gen #(.PIX_DIV(1)) u_d1 (
    .clk(clk), .rst(rst), .pix_en(d1_pix_en), .hsync(d1_hsync), .vsync(d1_vsync),
    .de(d1_de), .x(d1_x), .y(d1_y), .line_start(d1_ls), .frame_start(d1_fs),
    .frame_cnt(d1_fc));

  vga_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
                   .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
                   .PIX_DIV(1), .FRAME_W(2)) u_sm (
    .clk(clk), .rst(rst), .pix_en(sm_pix_en), .hsync(sm_hsync), .vsync(sm_vsync),
    .de(sm_de), .x(sm_x), .y(sm_y), .line_start(sm_ls), .frame_start(sm_fs),
    .frame_cnt(sm_fc));

  vga_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
                   .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
                   .H_POL(1'b1), .V_POL(1'b1), .PIX_DIV(1), .FRAME_W(2)) u_sp (
    .clk(clk), .rst(rst), .pix_en(sp_pix_en), .hsync(sp_hsync), .vsync(sp_vsync),
    .de(sp_de), .x(sp_x), .y(sp_y), .line_start(sp_ls), .frame_start(sp_fs),
    .frame_cnt(sp_fc));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // After this returns, the next posedge is edge 1 after reset release.
  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic check_d4_reset_values(input string name);
    logic [32:0] act, expv;
    act  = {d4_pix_en, d4_hsync, d4_vsync, d4_de, d4_x, d4_y, d4_ls, d4_fs, d4_fc};
    expv = {1'b0, 1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 8'd0};
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    check_d4_reset_values("reset_d4");
    checks++;
    if ({sp_hsync, sp_vsync, sp_de, sp_pix_en} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_pol: got %b expected 0000", {sp_hsync, sp_vsync, sp_de, sp_pix_en});
    end
    checks++;
    if ({sm_hsync, sm_vsync, sm_fc} !== 4'b1100) begin
      errors++;
      $display("FAIL reset_small: got %b expected 1100", {sm_hsync, sm_vsync, sm_fc});
    end
  endtask

  // Expects rst just released; walks edges 1..12 of the PIX_DIV=4 start-up trace.
  task automatic check_d4_startup(input string name);
    logic [22:0] act, expv;
    for (int e = 1; e <= 12; e++) begin
      step();
      checks++;
      if (d4_pix_en !== ((e % 4) == 0)) begin
        errors++;
        $display("FAIL %s_pix_en edge %0d: got %b expected %b", name, e, d4_pix_en, (e % 4) == 0);
      end
      if (e == 5 || e == 6 || e == 9) begin
        act = {d4_fs, d4_ls, d4_de, d4_x, d4_fc};
        if (e == 5)      expv = {1'b1, 1'b1, 1'b1, 10'd0, 8'd1};
        else if (e == 6) expv = {1'b0, 1'b0, 1'b1, 10'd0, 8'd1};
        else             expv = {1'b0, 1'b0, 1'b1, 10'd1, 8'd1};
        checks++;
        if (act !== expv || d4_y !== 10'd0) begin
          errors++;
          $display("FAIL %s_pos edge %0d: got %h y=%0d expected %h y=0", name, e, act, d4_y, expv);
        end
      end
    end
  endtask

  task automatic test_prescaler();
    do_reset();
    check_d4_startup("startup");
  endtask

  task automatic test_small_mode();
    logic [27:0] act, expv;
    int n, h, v, fs_count;
    logic de_e;
    do_reset();
    fs_count = 0;
    for (int e = 1; e <= 241; e++) begin
      step();
      if (sm_fs) fs_count++;
      act = {sm_pix_en, sm_hsync, sm_vsync, sm_de, sm_x, sm_y, sm_ls, sm_fs, sm_fc};
      if (e == 1) begin
        expv = {1'b1, 1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 2'd0};
        checks++;
        if ({sp_hsync, sp_vsync} !== 2'b00) begin
          errors++;
          $display("FAIL pol_edge1: got %b expected 00", {sp_hsync, sp_vsync});
        end
      end else begin
        n = e - 2;
        h = n % 8;
        v = (n / 8) % 6;
        de_e = (h < 4) && (v < 3);
        expv = {1'b1, !(h == 5 || h == 6), !(v == 4), de_e,
                de_e ? 10'(h) : 10'd0, de_e ? 10'(v) : 10'd0,
                h == 0, (n % 48) == 0, 2'((n / 48) + 1)};
        checks++;
        if ({sp_hsync, sp_vsync} !== {h == 5 || h == 6, v == 4}) begin
          errors++;
          $display("FAIL pol_sync n=%0d: got %b expected %b", n, {sp_hsync, sp_vsync},
                   {h == 5 || h == 6, v == 4});
        end
      end
      checks++;
      if (act !== expv) begin
        errors++;
        $display("FAIL small edge %0d: got %h expected %h", e, act, expv);
      end
    end
    checks++;
    if (fs_count != 5) begin
      errors++;
      $display("FAIL small_frames: got %0d frame_start pulses expected 5", fs_count);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    // (2,1) is pixel 802; advances happen on edges 5 + 4*k.
    for (int e = 1; e <= 3213; e++) step();
    checks++;
    if ({d4_de, d4_x, d4_y, d4_fc} !== {1'b1, 10'd2, 10'd1, 8'd1}) begin
      errors++;
      $display("FAIL pre_reset_pos: got de=%b x=%0d y=%0d fc=%0d expected 1 2 1 1",
               d4_de, d4_x, d4_y, d4_fc);
    end
    rst = 1'b1;
    step();
    check_d4_reset_values("mid_reset");
    rst = 1'b0;
    check_d4_startup("restart");
  endtask

  task automatic test_default_line();
    int first_ls, second_ls, first_hs_low, hs_low, de_cnt, ls_cnt, fs_cnt, vs_low;
    do_reset();
    first_ls = -1; second_ls = -1; first_hs_low = -1;
    hs_low = 0; de_cnt = 0; ls_cnt = 0; fs_cnt = 0; vs_low = 0;
    for (int e = 1; e <= 1601; e++) begin
      step();
      if (d1_ls) begin
        ls_cnt++;
        if (first_ls < 0) first_ls = e;
        else if (second_ls < 0) second_ls = e;
      end
      if (d1_fs) fs_cnt++;
      if (!d1_hsync) begin
        hs_low++;
        if (first_hs_low < 0) first_hs_low = e;
      end
      if (!d1_vsync) vs_low++;
      if (d1_de) de_cnt++;
    end
    checks++;
    if (first_ls != 2 || second_ls != 802) begin
      errors++;
      $display("FAIL line_period: got starts %0d,%0d expected 2,802", first_ls, second_ls);
    end
    checks++;
    if (first_hs_low - first_ls != 656) begin
      errors++;
      $display("FAIL hsync_offset: got %0d expected 656", first_hs_low - first_ls);
    end
    checks++;
    if (hs_low != 192) begin
      errors++;
      $display("FAIL hsync_width: got %0d expected 192", hs_low);
    end
    checks++;
    if (de_cnt != 1280) begin
      errors++;
      $display("FAIL de_count: got %0d expected 1280", de_cnt);
    end
    checks++;
    if (ls_cnt != 2 || fs_cnt != 1 || vs_low != 0) begin
      errors++;
      $display("FAIL strobes_d1: got ls=%0d fs=%0d vs_low=%0d expected 2 1 0",
               ls_cnt, fs_cnt, vs_low);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    test_reset();
    test_prescaler();
    test_small_mode();
    test_mid_reset();
    test_default_line();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
